fwd_select_ctrl: RTL and testbench

//  Produces the 2-bit `op` selects for the two 3-input 32-bit EX-stage operand muxes (ALU A and ALU B).

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/hz_stage_reg.sv | 22 ++
 rtl/fwd_select_ctrl.sv | 105 ++++++++++
 tb/tb_fwd_select_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the EX-stage forwarding / load-use hazard controller.
// Register-index width, operand-select codes, hazard FSM states and the shadow-stage record.
package pipeline_pkg;

    // The shadow-stage record is fixed at this width; the top's REG_AW must match it.
    localparam int HZ_REG_AW = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam logic [0:0] HZ_RUN  = 1'b0;
    localparam logic [0:0] HZ_HOLD = 1'b1;

    typedef struct packed {
        logic [HZ_REG_AW-1:0] rs1;
        logic [HZ_REG_AW-1:0] rs2;
        logic [HZ_REG_AW-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 valid;
    } hazard_fields_t;

    // True when a stage holds a live write to a non-zero register equal to rs.
    function automatic logic produces(input hazard_fields_t s, input logic [HZ_REG_AW-1:0] rs);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
    endfunction

    // Newest producer wins: EX/MEM is checked before MEM/WB.
    function automatic logic [1:0] fwd_select(input hazard_fields_t exmem,
                                              input hazard_fields_t memwb,
                                              input logic [HZ_REG_AW-1:0] rs);
        if (produces(exmem, rs))      return FWD_EXMEM;
        else if (produces(memwb, rs)) return FWD_MEMWB;
        else                          return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage: a synchronously reset register of hazard_fields_t.
// kill loads a bubble (all fields zero, valid = 0) instead of the incoming record.
module hz_stage_reg
    import pipeline_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           kill,
    input  hazard_fields_t d,
    output hazard_fields_t q
);

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (reset || kill) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fwd_select_ctrl.sv
// EX-stage operand-select and load-use stall controller.
// Shadows ID/EX, EX/MEM, MEM/WB destination info and drives the ALU A/B mux selects plus stall/bubble.
module fwd_select_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              bubble
);

    localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);

    hazard_fields_t id_f, idex, exmem, memwb;
    logic [0:0]     state;
    logic [1:0]     cnt;
    logic           hazard;
    logic           kill_idex;
    logic           unused_fields;

    assign id_f = '{rs1:       id_rs1,
                    rs2:       id_rs2,
                    rd:        id_rd,
                    reg_write: id_reg_write,
                    mem_read:  id_mem_read,
                    valid:     id_valid};

    assign kill_idex = stall | flush | ~id_valid;

    hz_stage_reg u_idex (
        .clk   (clk),
        .reset (reset),
        .kill  (kill_idex),
        .d     (id_f),
        .q     (idex)
    );

    hz_stage_reg u_exmem (
        .clk   (clk),
        .reset (reset),
        .kill  (1'b0),
        .d     (idex),
        .q     (exmem)
    );

    hz_stage_reg u_memwb (
        .clk   (clk),
        .reset (reset),
        .kill  (1'b0),
        .d     (exmem),
        .q     (memwb)
    );

    // Source indices and the load flag of the later stages are never compared.
    assign unused_fields = ^{exmem.rs1, exmem.rs2, exmem.mem_read,
                             memwb.rs1, memwb.rs2, memwb.mem_read};

    assign fwd_a = fwd_select(exmem, memwb, idex.rs1);
    assign fwd_b = fwd_select(exmem, memwb, idex.rs2);

    assign hazard = idex.valid & idex.mem_read & (idex.rd != '0) & id_valid &
                    ((idex.rd == id_rs1) | (idex.rd == id_rs2));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stall = 1'b0;
        if (!flush) begin
            stall = (state == HZ_HOLD) | hazard;
        end
    end

    // A flushed cycle still inserts a NOP even though PC/IF-ID are released.
    assign bubble = stall | flush;

    // A flush or reset abandons any stall in progress.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else if (state == HZ_RUN) begin
            if (hazard) begin
                cnt   <= CNT_LOAD;
                state <= (CNT_LOAD == 2'd0) ? HZ_RUN : HZ_HOLD;
            end
        end else begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
                state <= HZ_RUN;
            end
        end
    end

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Bench for fwd_select_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances on shared stimulus,
// checked every cycle against a history-based reference model, plus directed scenario checks.
module tb_fwd_select_ctrl;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0][1:0] fwd_a, fwd_b;
    logic [1:0]      stall, bubble;

    always #5 clk = ~clk;

    fwd_select_ctrl #(.REG_AW(5), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall(stall[0]), .bubble(bubble[0])
    );

    fwd_select_ctrl #(.REG_AW(5), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall(stall[1]), .bubble(bubble[1])
    );

    // Reference model: hist[m][k] is the instruction that entered EX at edge k.
    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ent_t;

    ent_t hist [2][MAXC];
    int   cur = 0;
    int   rst_mark [2] = '{0, 0};
    int   hold_left [2] = '{0, 0};
    int   lat [2] = '{1, 3};

    logic [1:0] exp_fa [2], exp_fb [2];
    logic       exp_stall [2], exp_bubble [2];
    logic [1:0] s_fa [2], s_fb [2];
    logic       s_stall [2], s_bubble [2];

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic ent_t get(int m, int age);
        int idx;
        idx = cur - age;
        if (idx < 0 || idx < rst_mark[m]) return '0;
        return hist[m][idx];
    endfunction

    // Selected source: the youngest of the two older in-flight instructions that writes rs.
    function automatic logic [1:0] exp_sel(int m, logic [4:0] rs);
        for (int age = 1; age <= 2; age++) begin
            ent_t p;
            p = get(m, age);
            if (p.valid && p.rw && p.rd != 5'd0 && p.rd == rs) return (age == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] mux3(logic [1:0] s);
        case (s)
            2'b00:   return 32'hAAAA_AAAA;
            2'b01:   return 32'hBBBB_BBBB;
            2'b10:   return 32'hCCCC_CCCC;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic model_eval(int m);
        ent_t e;
        logic hz;
        e  = get(m, 0);
        hz = e.valid && e.mr && e.rd != 5'd0 && id_valid && (e.rd == id_rs1 || e.rd == id_rs2);
        exp_stall[m]  = !flush && (hold_left[m] > 0 || hz);
        exp_bubble[m] = exp_stall[m] || flush;
        exp_fa[m]     = exp_sel(m, e.rs1);
        exp_fb[m]     = exp_sel(m, e.rs2);
        if (reset) begin
            hold_left[m] = 0;
        end else if (flush) begin
            hold_left[m] = 0;
        end else if (hold_left[m] > 0) begin
            hold_left[m] = hold_left[m] - 1;
        end else if (hz) begin
            hold_left[m] = lat[m] - 1;
        end
    endtask

    task automatic model_edge(int m);
        if (reset) begin
            rst_mark[m]       = cur + 1;
            hist[m][cur + 1]  = '0;
        end else if (exp_stall[m] || flush || !id_valid) begin
            hist[m][cur + 1] = '0;
        end else begin
            hist[m][cur + 1] = '{valid: 1'b1, rw: id_reg_write, mr: id_mem_read,
                                 rd: id_rd, rs1: id_rs1, rs2: id_rs2};
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven at the falling edge; sample 1 ns later, then advance.
    task automatic tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            model_eval(m);
            s_fa[m]     = fwd_a[m];
            s_fb[m]     = fwd_b[m];
            s_stall[m]  = stall[m];
            s_bubble[m] = bubble[m];
            if (chk_en) begin
                check($sformatf("lat%0d_fwd_a", lat[m]),  32'(s_fa[m]),     32'(exp_fa[m]));
                check($sformatf("lat%0d_fwd_b", lat[m]),  32'(s_fb[m]),     32'(exp_fb[m]));
                check($sformatf("lat%0d_stall", lat[m]),  32'(s_stall[m]),  32'(exp_stall[m]));
                check($sformatf("lat%0d_bubble", lat[m]), 32'(s_bubble[m]), 32'(exp_bubble[m]));
                check($sformatf("lat%0d_mux_a", lat[m]),  mux3(s_fa[m]),    mux3(exp_fa[m]));
                check($sformatf("lat%0d_sel_not_11", lat[m]),
                      32'((s_fa[m] === 2'b11) || (s_fb[m] === 2'b11)), 32'd0);
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_edge(m);
        cur++;
        @(negedge clk);
    endtask

    task automatic drive(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                         logic rw, logic mr, logic fl);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    task automatic issue(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic rw, logic mr);
        drive(1'b1, rs1, rs2, rd, rw, mr, 1'b0);
        tick();
    endtask

    task automatic idle(int n);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        int cnt1, cnt3;
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Idle after reset: everything quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_fwd_a", 32'(s_fa[0]), 32'd0);
            check("idle_fwd_b", 32'(s_fb[0]), 32'd0);
            check("idle_stall", 32'(s_stall[0]), 32'd0);
            check("idle_bubble", 32'(s_bubble[0]), 32'd0);
        end

        // Back-to-back dependency forwards from EX/MEM, one apart from MEM/WB.
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 5'd7, 5'd6, 1'b1, 1'b0);
        check("dep1_fwd_a", 32'(fwd_a[0]), 32'h1);
        check("dep1_fwd_b", 32'(fwd_b[0]), 32'h0);
        idle(3);
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        issue(5'd10, 5'd11, 5'd9, 1'b1, 1'b0);
        issue(5'd5, 5'd7, 5'd12, 1'b1, 1'b0);
        check("dep2_fwd_a", 32'(fwd_a[0]), 32'h2);
        idle(3);

        // Two writers to r3: newest (EX/MEM) wins; r0 never forwards.
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
        check("prio_fwd_a", 32'(fwd_a[0]), 32'h1);
        check("prio_fwd_b", 32'(fwd_b[0]), 32'h1);
        idle(3);
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        check("r0_fwd_a", 32'(fwd_a[0]), 32'h0);
        check("r0_fwd_b", 32'(fwd_b[0]), 32'h0);
        idle(3);

        // Load-use: consumer held in ID; count stall cycles per instance.
        issue(5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
        drive(1'b1, 5'd1, 5'd8, 5'd13, 1'b1, 1'b0, 1'b0);
        cnt1 = 0;
        cnt3 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt1 += int'(s_stall[0]);
            cnt3 += int'(s_stall[1]);
            if (i == 2) check("lu_consumer_fwd_b", 32'(s_fb[0]), 32'h2);
        end
        check("lu_stall_cycles_lat1", 32'(cnt1), 32'd1);
        check("lu_stall_cycles_lat3", 32'(cnt3), 32'd3);
        idle(3);

        // Flush in the hazard cycle: no stall, bubble, and no lingering hold.
        issue(5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
        drive(1'b1, 5'd8, 5'd1, 5'd13, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_stall", 32'(s_stall[1]), 32'd0);
        check("flush_bubble", 32'(s_bubble[1]), 32'd1);
        idle(1);
        check("flush_after_stall", 32'(s_stall[1]), 32'd0);
        idle(3);

        // Reset while the LOAD_LAT=3 instance is in HOLD.
        issue(5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
        drive(1'b1, 5'd8, 5'd1, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold_entry_stall", 32'(s_stall[1]), 32'd1);
        reset = 1'b1;
        tick();
        check("hold_reset_cycle_stall", 32'(s_stall[1]), 32'd1);
        reset = 1'b0;
        tick();
        check("hold_after_reset_stall", 32'(s_stall[1]), 32'd0);
        idle(3);

        // Randomised traffic on a small register set to provoke overlaps.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            tick();
        end
        reset = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
